gfield_div_eight: RTL
=====================

// Module: gfield_div_eight
// PURPOSE
//  Sequential GF(2^8) divider: q = a / b = a * b^254. It is the inverse of GF(2^8) multiplication.
//  It complements the combinational GField adders (GF add = GF subtract = XOR) so the GField arithmetic set is complete.
//  Uses two bit-serial GF multipliers driven by a start/busy/done handshake.
//  Consumers: the Reed-Solomon/AES-style datapaths built on the GField blocks.
// PARAMETERS
//  POLY  9'h11B  reduction polynomial, bit 8 = x^8 coeff; must be irreducible with bit 8 = 1.
//                Only POLY[7:0] is used in reduction.
// PORTS
//  clk    in   1      system clock; all state changes on rising edge
//  reset  in   1      synchronous, active-high reset
//  start  in   1      request; sampled only in IDLE
//  a      in   [0:7]  dividend; bit 0 = x^7 coeff (same ordering as GFieldAddEight)
//  b      in   [0:7]  divisor, same ordering
//  busy   out  1      high in RUN
//  done   out  1      one-cycle pulse, result valid
//  q      out  [0:7]  quotient; registered, held until next accepted start
//  err    out  1      divide-by-zero flag; valid with done, held with q
// BEHAVIOUR
//  Reset (sync, active-high, priority over everything): state=IDLE; busy=0, done=0, q=8'h00, err=0.
//  Reset mid-RUN aborts the operation and discards partial results.
//  States:
//   IDLE: on start=1, capture acc<=a, sq<=b, rnd<=0, bit<=0.
//         If b==0: go to DONE with q<=0, err<=1. Else go to RUN, err<=0.
//   RUN:  64 cycles = 8 rounds x 8 bit-steps. done=0.
//   DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
//  Rounds:
//   round 0 updates only sq: sq<=sq*sq.
//   rounds 1..7 update both in parallel: acc<=acc*sq and sq<=sq*sq, with both products using the old sq.
//   After round 7, acc = a*b^254 = a/b. q<=acc on the RUN->DONE transition.
//  Bit-serial multiply x*y, MSB-first, 8 steps:
//   p<=0, then for i=7..0: p <= xt(p) ^ (y[i] ? x : 0).
//   xt(p) = {p[6:0],0} ^ (p[7] ? POLY[7:0] : 0), where p[7] is the x^7 coeff.
//   The product is latched into acc/sq at step 7; x and y stay stable for the whole round.
//  Latency: start sampled at edge T.
//   b!=0: done high in the cycle after edge T+65 (RUN covers edges T+1..T+64, DONE state entered at edge T+65).
//   b==0: done high in the cycle after edge T+1.
//  a and b may change freely after the accept edge; the captured copies are used.
//  start while busy or in DONE: ignored, no queuing.
//  a==0, b!=0: full-latency path, q=0, err=0.
//  b==1: q=a.
//  Outputs are fully registered; no combinational input->output path.
// TESTING
//  T1 a=8'h01, b=8'h53, start pulse -> done after 65 cycles, q=8'hCA, err=0; busy high exactly 64 cycles.
//  T2 a=8'hC1, b=8'h83 -> q=8'h57.
//     a=8'h57, b=8'h01 -> q=8'h57.
//     a=8'h00, b=8'h53 -> q=8'h00.
//  T3 a=8'h12, b=8'h00 -> done one cycle after accept, q=8'h00, err=1, busy never high.
//  T4 start held high continuously, first op a=01/b=53 -> exactly one done per 66 cycles.
//     Changing a/b mid-RUN does not affect q (still CA).
//  T5 reset asserted at RUN cycle 30 -> next cycle busy=0, done=0, q=00, err=0.
//     New op a=C1/b=83 then yields 57.
//  T6 random a, b (b!=0), 1000 ops -> GFmul(q,b)==a against a behavioural model; q/err held stable between done pulses.

Source files
------------

// File: rtl/gfield_div_eight.sv
// Sequential GF(2^8) divider: q = a / b computed as a * b^254.
// Eight rounds of square-and-multiply, each round built from two bit-serial
// MSB-first multipliers running in lock-step (acc*sq and sq*sq).
// Port vectors use [0:7] ordering (bit 0 = x^7 coefficient); internally the
// datapath is [7:0] with bit 7 = x^7, so a plain assignment maps one onto the other.
module gfield_div_eight #(
  parameter logic [8:0] POLY = 9'h11B
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [0:7] a,
  input  logic [0:7] b,
  output logic       busy,
  output logic       done,
  output logic [0:7] q,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;

  logic [7:0] acc_r;     // running product, ends as a * b^254
  logic [7:0] sq_r;      // repeated square of b
  logic [7:0] pa_r;      // partial product for acc * sq
  logic [7:0] ps_r;      // partial product for sq * sq
  logic [2:0] step_r;    // bit-step within a round, 0..7
  logic [2:0] rnd_r;     // round index, 0..7
  logic       zdiv_r;    // captured divisor was zero

  logic [7:0] a_s;
  logic [7:0] b_s;
  logic       ybit_s;
  logic [7:0] pa_next_s;
  logic [7:0] ps_next_s;
  logic       last_step_s;
  logic       last_rnd_s;

  // Multiply by x with reduction modulo POLY (only the low 8 bits matter).
  function automatic logic [7:0] xt(input logic [7:0] p);
    xt = {p[6:0], 1'b0} ^ (p[7] ? POLY[7:0] : 8'h00);
  endfunction

  // Re-order inputs into the internal bit numbering.
  always_comb begin
    a_s = a;
    b_s = b;
  end

  // One MSB-first step of both bit-serial multipliers; the partial product
  // restarts from zero on step 0 so no separate clear cycle is needed.
  always_comb begin
    ybit_s      = sq_r[3'd7 - step_r];
    pa_next_s   = xt((step_r == 3'd0) ? 8'h00 : pa_r) ^ (ybit_s ? acc_r : 8'h00);
    ps_next_s   = xt((step_r == 3'd0) ? 8'h00 : ps_r) ^ (ybit_s ? sq_r  : 8'h00);
    last_step_s = (step_r == 3'd7);
    last_rnd_s  = (rnd_r == 3'd7);
  end

  // Next-state logic for the IDLE/RUN/DONE handshake.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (b_s == 8'h00) begin
            state_s = DONE;
          end else begin
            state_s = RUN;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_step_s && last_rnd_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture and square-and-multiply datapath; round 0 only squares,
  // later rounds update acc and sq together from the same old sq.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r  <= 8'h00;
      sq_r   <= 8'h00;
      pa_r   <= 8'h00;
      ps_r   <= 8'h00;
      step_r <= 3'd0;
      rnd_r  <= 3'd0;
      zdiv_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            acc_r  <= a_s;
            sq_r   <= b_s;
            step_r <= 3'd0;
            rnd_r  <= 3'd0;
            zdiv_r <= (b_s == 8'h00);
          end
        end
        RUN: begin
          pa_r   <= pa_next_s;
          ps_r   <= ps_next_s;
          step_r <= step_r + 3'd1;
          if (last_step_s) begin
            sq_r  <= ps_next_s;
            rnd_r <= rnd_r + 3'd1;
            if (rnd_r != 3'd0) begin
              acc_r <= pa_next_s;
            end
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Registered handshake and result outputs; q/err change only when done fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      q    <= 8'h00;
      err  <= 1'b0;
    end else begin
      busy <= (state_s == RUN);
      done <= (state_r == DONE);
      if (state_r == DONE) begin
        q   <= zdiv_r ? 8'h00 : acc_r;
        err <= zdiv_r;
      end
    end
  end

endmodule
